// File: rtl/axis_pingpong_packetizer.sv
// Two-bank AXI-Stream packetizer: one bank fills from the ADC while the other
// is drained as a TLAST-terminated packet, with an interrupt pulse per packet.
module axis_pingpong_packetizer #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned SMPLS        = 32,
  parameter int unsigned INTR_CLKS    = 8,
  parameter bit          DROP_ON_FULL = 1'b0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_interrupt,
  output logic                  overflow,
  input  logic                  overflow_clr,
  output logic [15:0]           pkt_cnt
);

  localparam int unsigned IDXW = $clog2(SMPLS);
  localparam int unsigned ICW  = $clog2(INTR_CLKS + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SMPLS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [DATA_WIDTH-1:0] bank_q [2][SMPLS];
  logic [1:0]            full_q, full_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [IDXW-1:0]       wr_idx_q, wr_idx_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [IDXW-1:0]       rd_idx_q, rd_idx_d;
  state_t                state_q, state_d;
  logic [ICW-1:0]        intr_q, intr_d;
  logic                  ovf_q, ovf_d;
  logic [15:0]           pkt_q, pkt_d;

  logic full_hit, s_ready, wr_en, wr_wrap, rd_release;

  always_comb begin
    full_hit  = full_q[wr_bank_q];
    s_ready   = DROP_ON_FULL ? 1'b1 : !full_hit;
    // in drop mode a beat can handshake against a full bank; it is discarded
    wr_en     = s_axis_tvalid && s_ready && !full_hit;
    wr_wrap   = wr_en && (wr_idx_q == LAST_IDX);
    wr_bank_d = wr_bank_q;
    wr_idx_d  = wr_idx_q;
    if (wr_en) begin
      if (wr_wrap) begin
        wr_idx_d  = '0;
        wr_bank_d = !wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
    ovf_d = ovf_q;
    if (overflow_clr) ovf_d = 1'b0;
    if (s_axis_tvalid && full_hit) ovf_d = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    rd_bank_d     = rd_bank_q;
    rd_idx_d      = rd_idx_q;
    pkt_d         = pkt_q;
    rd_release    = 1'b0;
    intr_d        = (intr_q != '0) ? intr_q - 1'b1 : intr_q;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    unique case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = SEND;
          intr_d  = ICW'(INTR_CLKS);
        end
      end
      SEND: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = bank_q[rd_bank_q][rd_idx_q];
        m_axis_tlast  = (rd_idx_q == LAST_IDX);
        if (m_axis_tready) begin
          if (m_axis_tlast) begin
            rd_release = 1'b1;
            rd_idx_d   = '0;
            rd_bank_d  = !rd_bank_q;
            pkt_d      = pkt_q + 16'd1;
            state_d    = IDLE;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // read and write always touch different banks, so both updates apply
    full_d = full_q;
    if (rd_release) full_d[rd_bank_q] = 1'b0;
    if (wr_wrap)    full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
      state_q   <= IDLE;
      intr_q    <= '0;
      ovf_q     <= 1'b0;
      pkt_q     <= '0;
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned i = 0; i < SMPLS; i++)
          bank_q[b][i] <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
      state_q   <= state_d;
      intr_q    <= intr_d;
      ovf_q     <= ovf_d;
      pkt_q     <= pkt_d;
      if (wr_en) bank_q[wr_bank_q][wr_idx_q] <= s_axis_tdata;
    end
  end

  assign s_axis_tready    = s_ready;
  assign m_axis_interrupt = (intr_q != '0);
  assign overflow         = ovf_q;
  assign pkt_cnt          = pkt_q;

endmodule

// File: tb/tb_axis_pingpong_packetizer.sv
// Bench for axis_pingpong_packetizer: cycle table for one packet, scoreboard
// for streamed traffic, plus backpressure, ping-pong, drop-mode and reset runs.
module tb_axis_pingpong_packetizer;
  localparam int DW = 16;
  localparam int NS = 4;

  logic aclk = 1'b0;
  logic aresetn = 1'b1;
  always #5 aclk = ~aclk;

  logic s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b0, m_last, intr, ovf, ovf_clr = 1'b0;
  logic [DW-1:0] s_data = '0, m_data;
  logic [15:0] pkt_cnt;

  logic d_s_valid = 1'b0, d_s_ready, d_m_valid, d_m_ready = 1'b0, d_m_last, d_intr, d_ovf, d_ovf_clr = 1'b0;
  logic [DW-1:0] d_s_data = '0, d_m_data;
  logic [15:0] d_pkt_cnt;

  axis_pingpong_packetizer #(.DATA_WIDTH(DW), .SMPLS(NS), .INTR_CLKS(8), .DROP_ON_FULL(1'b0)) u_dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tdata(s_data),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tdata(m_data), .m_axis_tlast(m_last),
    .m_axis_interrupt(intr), .overflow(ovf), .overflow_clr(ovf_clr), .pkt_cnt(pkt_cnt));

  axis_pingpong_packetizer #(.DATA_WIDTH(DW), .SMPLS(NS), .INTR_CLKS(8), .DROP_ON_FULL(1'b1)) u_drop (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(d_s_valid), .s_axis_tready(d_s_ready), .s_axis_tdata(d_s_data),
    .m_axis_tvalid(d_m_valid), .m_axis_tready(d_m_ready), .m_axis_tdata(d_m_data), .m_axis_tlast(d_m_last),
    .m_axis_interrupt(d_intr), .overflow(d_ovf), .overflow_clr(d_ovf_clr), .pkt_cnt(d_pkt_cnt));

  int tests_run = 0;
  int fails = 0;

  typedef struct packed {logic last; logic [DW-1:0] data;} beat_t;
  beat_t sb[$];
  beat_t got_d[$];
  beat_t mon_in, mon_exp, held;
  int acc_n = 0;
  int beats_seen = 0;
  logic stalled = 1'b0;

  typedef struct {
    logic s_valid; logic [DW-1:0] s_data; logic m_ready;
    logic e_s_ready; logic e_m_valid; logic e_m_last; logic e_intr; logic [DW-1:0] e_m_data;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: accepted input samples become expected output beats
  initial begin : monitor
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if (s_valid && s_ready) begin
          mon_in.last = ((acc_n % NS) == NS - 1);
          mon_in.data = s_data;
          sb.push_back(mon_in);
          acc_n++;
        end
        if (stalled) begin
          check("stall_valid", {31'd0, m_valid}, 32'd1);
          check("stall_data", {16'd0, m_data}, {16'd0, held.data});
          check("stall_last", {31'd0, m_last}, {31'd0, held.last});
        end
        if (m_valid && m_ready) begin
          beats_seen++;
          if (sb.size() == 0) begin
            tests_run++;
            fails++;
            $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_data);
          end else begin
            mon_exp = sb.pop_front();
            check("beat_data", {16'd0, m_data}, {16'd0, mon_exp.data});
            check("beat_last", {31'd0, m_last}, {31'd0, mon_exp.last});
          end
        end
        stalled = m_valid && !m_ready;
        held = {m_last, m_data};
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin : drop_monitor
    forever begin
      @(negedge aclk);
      if (aresetn && d_m_valid && d_m_ready) got_d.push_back(beat_t'({d_m_last, d_m_data}));
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_main(input logic [DW-1:0] first, input int n, input int budget);
    int k = 0;
    int cyc = 0;
    logic hs;
    while (k < n && cyc < budget) begin
      s_valid = 1'b1;
      s_data = first + DW'(k);
      @(negedge aclk);
      hs = s_ready;
      @(posedge aclk); #1;
      if (hs) k++;
      cyc++;
    end
    s_valid = 1'b0;
    if (k < n) begin
      tests_run++;
      fails++;
      $display("FAIL drive_timeout: accepted %0d samples, expected %0d", k, n);
    end
  endtask

  task automatic wait_drain(input int budget);
    int cyc = 0;
    do begin
      @(negedge aclk); #1;
      cyc++;
    end while ((sb.size() != 0 || m_valid) && cyc < budget);
    if (sb.size() != 0 || m_valid) begin
      tests_run++;
      fails++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
    end
    @(posedge aclk); #1;
  endtask

  initial begin
    //          s_valid s_data  m_rdy  e_srdy e_mval e_mlast e_intr e_mdata
    vecs[0]  = '{1'b1, 16'h1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
    vecs[1]  = '{1'b1, 16'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
    vecs[2]  = '{1'b1, 16'h3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
    vecs[3]  = '{1'b1, 16'h4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
    vecs[4]  = '{1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
    vecs[5]  = '{1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1};
    vecs[6]  = '{1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h2};
    vecs[7]  = '{1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h3};
    vecs[8]  = '{1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h4};
    vecs[9]  = '{1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0};
    vecs[10] = '{1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0};
    vecs[11] = '{1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0};
    vecs[12] = '{1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0};
    vecs[13] = '{1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};

    #1 aresetn = 1'b0;
    #2;
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_last", {31'd0, m_last}, 32'd0);
    check("rst_m_data", {16'd0, m_data}, 32'd0);
    check("rst_intr", {31'd0, intr}, 32'd0);
    check("rst_overflow", {31'd0, ovf}, 32'd0);
    check("rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    repeat (2) @(posedge aclk);
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;

    // Single packet, cycle by cycle
    for (int i = 0; i < 14; i++) begin
      s_valid = vecs[i].s_valid;
      s_data  = vecs[i].s_data;
      m_ready = vecs[i].m_ready;
      @(negedge aclk);
      check($sformatf("v%0d_s_ready", i), {31'd0, s_ready}, {31'd0, vecs[i].e_s_ready});
      check($sformatf("v%0d_m_valid", i), {31'd0, m_valid}, {31'd0, vecs[i].e_m_valid});
      check($sformatf("v%0d_m_last", i), {31'd0, m_last}, {31'd0, vecs[i].e_m_last});
      check($sformatf("v%0d_intr", i), {31'd0, intr}, {31'd0, vecs[i].e_intr});
      if (vecs[i].e_m_valid)
        check($sformatf("v%0d_m_data", i), {16'd0, m_data}, {16'd0, vecs[i].e_m_data});
      @(posedge aclk); #1;
    end
    s_valid = 1'b0;
    check("single_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);

    // Output backpressure with m_ready alternating
    fork
      drive_main(16'h0011, 4, 50);
      begin
        for (int c = 0; c < 30; c++) begin
          @(posedge aclk); #1;
          m_ready = ((c % 2) == 1);
        end
        m_ready = 1'b1;
      end
    join
    wait_drain(60);
    check("bp_pkt_cnt", {16'd0, pkt_cnt}, 32'd2);

    // Ping-pong with output stalled: third packet waits for a free bank
    m_ready = 1'b0;
    fork
      drive_main(16'h0021, 12, 200);
      begin
        repeat (12) @(posedge aclk);
        #2;
        check("pp_s_ready_low", {31'd0, s_ready}, 32'd0);
        check("pp_overflow", {31'd0, ovf}, 32'd1);
        check("pp_m_valid_held", {31'd0, m_valid}, 32'd1);
        m_ready = 1'b1;
      end
    join
    wait_drain(100);
    check("pp_pkt_cnt", {16'd0, pkt_cnt}, 32'd5);
    check("pp_overflow_sticky", {31'd0, ovf}, 32'd1);
    ovf_clr = 1'b1;
    @(posedge aclk); #1;
    ovf_clr = 1'b0;
    @(negedge aclk);
    check("ovf_clr", {31'd0, ovf}, 32'd0);
    @(posedge aclk); #1;

    // Concurrent fill/drain: 10 packets, one idle input cycle per packet
    for (int p = 0; p < 10; p++) begin
      drive_main(16'h0100 + DW'(p * 4), 4, 20);
      @(negedge aclk);
      if (p >= 1) check($sformatf("cc%0d_intr_held", p), {31'd0, intr}, 32'd1);
      @(posedge aclk); #1;
    end
    wait_drain(60);
    check("cc_overflow", {31'd0, ovf}, 32'd0);
    check("cc_pkt_cnt", {16'd0, pkt_cnt}, 32'd15);
    repeat (8) @(posedge aclk);
    @(negedge aclk);
    check("cc_intr_done", {31'd0, intr}, 32'd0);
    @(posedge aclk); #1;

    // Drop mode on the second instance
    for (int i = 0; i < 12; i++) begin
      d_s_valid = 1'b1;
      d_s_data = 16'h0051 + DW'(i);
      @(negedge aclk);
      check($sformatf("drop%0d_s_ready", i), {31'd0, d_s_ready}, 32'd1);
      @(posedge aclk); #1;
    end
    d_s_valid = 1'b0;
    check("drop_overflow", {31'd0, d_ovf}, 32'd1);
    d_m_ready = 1'b1;
    repeat (40) @(negedge aclk);
    check("drop_beat_count", got_d.size(), 32'd8);
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      check($sformatf("drop_beat%0d_data", i), {16'd0, got_d[i].data}, 32'h51 + i);
      check($sformatf("drop_beat%0d_last", i), {31'd0, got_d[i].last}, {31'd0, ((i % 4) == 3)});
    end
    check("drop_pkt_cnt", {16'd0, d_pkt_cnt}, 32'd2);
    @(posedge aclk); #1;
    d_ovf_clr = 1'b1;
    @(posedge aclk); #1;
    d_ovf_clr = 1'b0;
    @(negedge aclk);
    check("drop_ovf_clr", {31'd0, d_ovf}, 32'd0);
    @(posedge aclk); #1;

    // Reset in the middle of a packet, then a clean packet afterwards
    m_ready = 1'b1;
    begin
      int base;
      int cyc;
      base = beats_seen;
      cyc = 0;
      drive_main(16'h0031, 4, 20);
      while (beats_seen < base + 2 && cyc < 50) begin
        @(negedge aclk); #1;
        cyc++;
      end
      if (beats_seen < base + 2) begin
        tests_run++;
        fails++;
        $display("FAIL midsend_timeout: saw %0d beats, expected 2", beats_seen - base);
      end
    end
    @(posedge aclk); #1;
    aresetn = 1'b0;
    #1;
    check("mrst_s_ready", {31'd0, s_ready}, 32'd1);
    check("mrst_m_valid", {31'd0, m_valid}, 32'd0);
    check("mrst_m_last", {31'd0, m_last}, 32'd0);
    check("mrst_m_data", {16'd0, m_data}, 32'd0);
    check("mrst_intr", {31'd0, intr}, 32'd0);
    check("mrst_overflow", {31'd0, ovf}, 32'd0);
    check("mrst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    sb.delete();
    acc_n = 0;
    @(posedge aclk);
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;
    drive_main(16'h0041, 4, 20);
    wait_drain(50);
    check("post_rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/axis_pingpong_packetizer.md
# axis_pingpong_packetizer

Multi-buffered AXI4-Stream packetizer for the ADC-to-Microblaze path. It collects SMPLS samples from the ADC stream into one of two banks. While that bank is drained to the processor as a TLAST-terminated packet, the other bank keeps filling. An interrupt pulse is raised for each packet, and ADC samples are not lost during readout. It uses full AXI-Stream handshakes on both sides, with configurable overflow handling and status counters.

## Interface
- DATA_WIDTH, 16: tdata width in bits.
- SMPLS, 32: samples per packet; must be ≥2.
- INTR_CLKS, 8: interrupt pulse width in aclk cycles; must be ≥1.
- DROP_ON_FULL, 0: 0 = backpressure the ADC when both banks are full; 1 = keep s_axis_tready high and discard samples.
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- s_axis_tvalid  in  1  ADC sample valid.
- s_axis_tready  out  1  block can accept a sample.
- s_axis_tdata  in  DATA_WIDTH  ADC sample.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  processor accepts the beat.
- m_axis_tdata  out  DATA_WIDTH  output sample.
- m_axis_tlast  out  1  last beat of a packet.
- m_axis_interrupt  out  1  packet-ready pulse.
- overflow  out  1  sticky flag: a sample was refused or dropped.
- overflow_clr  in  1  clears overflow.
- pkt_cnt  out  16  number of completed output packets, modulo 2^16.

## Operation
- Storage: two banks of SMPLS×DATA_WIDTH, with a full flag per bank.
- Write side:
  - Registers: wr_bank (1b) and wr_idx ($clog2(SMPLS)b).
  - A sample is accepted when s_axis_tvalid && s_axis_tready; it is written to bank[wr_bank][wr_idx].
  - On an accept with wr_idx==SMPLS-1: set full[wr_bank], toggle wr_bank, reset wr_idx to 0.
- s_axis_tready:
  - DROP_ON_FULL=0: s_axis_tready = !full[wr_bank].
  - DROP_ON_FULL=1: s_axis_tready = 1. A beat presented while full[wr_bank] is discarded; no write, no index change.
- overflow is set in any cycle with s_axis_tvalid && full[wr_bank], in either mode. overflow_clr clears it. If set and clear occur in the same cycle, set wins.
- Read side: FSM with states IDLE and SEND; registers rd_bank (1b) and rd_idx.
  - IDLE: go to SEND when full[rd_bank]=1. On that transition, load the interrupt counter with INTR_CLKS.
  - SEND:
    - m_axis_tvalid=1.
    - m_axis_tdata = bank[rd_bank][rd_idx], combinational read.
    - m_axis_tlast = (rd_idx==SMPLS-1).
    - On each handshake, rd_idx increments.
    - On the handshake with tlast: clear full[rd_bank], toggle rd_bank, reset rd_idx to 0, increment pkt_cnt (0xFFFF wraps to 0), and return to IDLE.
- The write side never writes a full bank, so tdata stays stable during a stall.
- m_axis_interrupt is high while the interrupt counter is nonzero. The counter decrements each cycle. A new SEND entry reloads it, so back-to-back packets extend the pulse.
- Banks are filled and drained strictly alternately, starting with bank 0, so packet order equals arrival order.

## Timing
- Reset values: s_axis_tready=1 (both banks empty), m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_interrupt=0, overflow=0, pkt_cnt=0. Both full flags, both banks, all indices and the FSM also reset to 0 / IDLE.
- Reset mid-operation: asynchronous. Outputs go to their reset values immediately and in-flight packets are discarded.
- Latency:
  - The last sample of a packet is accepted at edge E, so full is set after E.
  - At edge E+1 the FSM enters SEND; m_axis_tvalid and m_axis_interrupt are high from E+1.
  - The interrupt stays high for exactly INTR_CLKS cycles unless it is retriggered.
- Sustained throughput: 1 beat/cycle out when m_axis_tready=1. There is 1 idle cycle (IDLE) between packets.
- Bank release:
  - Releasing a bank at the tlast handshake edge makes s_axis_tready rise in the following cycle (DROP_ON_FULL=0).
  - A write completing one bank on the same edge that the read releases the other bank is legal; both updates take effect.
- AXIS rules: the output never drops m_axis_tvalid without a handshake. m_axis_tdata and m_axis_tlast are held while m_axis_tvalid && !m_axis_tready.

## Test plan
- Single packet: SMPLS=4, INTR_CLKS=8, input 0x0001..0x0004 back-to-back, m_axis_tready=1.
  - Output beats 1,2,3,4, with tlast on beat 4 only.
  - Interrupt high for 8 cycles starting the edge after the 4th accept.
  - pkt_cnt=1.
- Output backpressure: same stimulus, m_axis_tready alternating 0/1.
  - tdata, tvalid and tlast stable through each stall.
  - Order 1..4 preserved; no duplicate beats.
- Ping-pong, DROP_ON_FULL=0: SMPLS=4, m_axis_tready=0, 12 samples offered continuously.
  - s_axis_tready goes low after sample 8, and overflow=1.
  - After m_axis_tready is raised, packets {1..4} and {5..8} are output; samples 9..12 are then accepted and output as packet 3.
  - pkt_cnt=3.
- Drop mode, DROP_ON_FULL=1: same stimulus.
  - s_axis_tready stays 1 and samples 9..12 are discarded.
  - overflow=1; only packets {1..4} and {5..8} are output.
  - Pulsing overflow_clr clears overflow.
- Concurrent fill/drain: continuous input with m_axis_tready=1 for 10 packets.
  - No overflow; pkt_cnt=10.
  - Interrupt retriggers each packet, with the pulse extended whenever packets complete within INTR_CLKS.
- Reset mid-SEND: drop aresetn after beat 2 of packet 1.
  - All outputs at reset values the same cycle.
  - After release, a new 4-sample input is output from bank 0 starting at index 0.
